// File: rtl/stopwatch_pkg.sv
// Shared state encoding and mode-LED constants for the stopwatch controller.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    LIMIT   = 2'd3
  } sw_state_e;

  localparam int MODE_DOWN_BIT  = 0;
  localparam int MODE_UP_BIT    = 1;
  localparam int MODE_LIMIT_BIT = 2;

  localparam logic [2:0] MODE_RESET = 3'b010;

endpackage

// File: rtl/stopwatch_tick_prescaler.sv
// Power-of-two prescaler: Tick fires when the count reaches (1<<Speed)-1,
// or immediately if Speed shrank below the current count.
module stopwatch_tick_prescaler #(
  parameter int DIV_WIDTH = 32
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Enable,
  input  logic       Restart,
  input  logic [4:0] Speed,
  output logic       Tick
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d, term;

  always_comb begin
    term  = (DIV_WIDTH'(1) << Speed) - DIV_WIDTH'(1);
    cnt_d = cnt_q;
    Tick  = 1'b0;
    if (Restart || !Enable) begin
      cnt_d = '0;
    end else if (cnt_q >= term) begin
      cnt_d = '0;
      Tick  = 1'b1;
    end else begin
      cnt_d = cnt_q + DIV_WIDTH'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/stopwatch_controller.sv
// Stopwatch control FSM: button edge detection, run/pause/clear/lap sequencing,
// direction select, limit stop and the registered count-enable tick.
module stopwatch_controller
  import stopwatch_pkg::*;
#(
  parameter int DIV_WIDTH = 32,
  parameter bit AUTO_STOP = 1'b1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       StartStop,
  input  logic       Up,
  input  logic       Down,
  input  logic       Lap,
  input  logic [4:0] Speed,
  input  logic       AtMax,
  input  logic       AtZero,
  output logic       CountEnable,
  output logic       CountDir,
  output logic       CounterClear,
  output logic       DisplayFreeze,
  output logic [2:0] ModeOutput,
  output logic [1:0] State
);

  sw_state_e  state_q, state_d;
  logic       dir_q, dir_d;
  logic       ce_q, ce_d;
  logic       clr_q, clr_d;
  logic       frz_q, frz_d;
  logic [2:0] mode_q, mode_d;
  logic       ss_q, up_q, dn_q, lap_q;
  logic       ev_ss, ev_up, ev_dn, ev_lap;
  logic       tick, at_bound, restart, run_en;

  assign ev_ss  = StartStop & ~ss_q;
  assign ev_up  = Up        & ~up_q;
  assign ev_dn  = Down      & ~dn_q;
  assign ev_lap = Lap       & ~lap_q;

  // Bound is judged against the direction currently in force, not a pending change.
  assign at_bound = (dir_q & AtMax) | (~dir_q & AtZero);
  assign run_en   = (state_q == RUNNING);

  stopwatch_tick_prescaler #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_prescaler (
    .Clk    (Clk),
    .Reset  (Reset),
    .Enable (run_en),
    .Restart(restart),
    .Speed  (Speed),
    .Tick   (tick)
  );

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    ce_d    = 1'b0;
    clr_d   = 1'b0;
    frz_d   = frz_q;

    if (ev_up && !ev_dn)      dir_d = 1'b1;
    else if (ev_dn && !ev_up) dir_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (ev_ss)       state_d = RUNNING;
        else if (ev_lap) clr_d   = 1'b1;
      end
      RUNNING: begin
        ce_d = tick & ~at_bound;
        if (ev_ss) begin
          state_d = PAUSED;
        end else begin
          if (tick && at_bound && AUTO_STOP) state_d = LIMIT;
          if (ev_lap) frz_d = ~frz_q;
        end
      end
      PAUSED: begin
        if (ev_ss) begin
          state_d = RUNNING;
        end else if (ev_lap) begin
          clr_d   = 1'b1;
          state_d = IDLE;
        end
      end
      LIMIT: begin
        if (ev_ss) begin
          if (!at_bound) state_d = RUNNING;
        end else if (ev_lap) begin
          clr_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == IDLE) frz_d = 1'b0;

    restart                = (state_d == RUNNING) && (state_q != RUNNING);
    mode_d                 = '0;
    mode_d[MODE_DOWN_BIT]  = ~dir_d;
    mode_d[MODE_UP_BIT]    = dir_d;
    mode_d[MODE_LIMIT_BIT] = (state_d == LIMIT);
  end

  // History flops reset to 1 so a button held through reset yields no edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      dir_q   <= 1'b1;
      ce_q    <= 1'b0;
      clr_q   <= 1'b0;
      frz_q   <= 1'b0;
      mode_q  <= MODE_RESET;
      ss_q    <= 1'b1;
      up_q    <= 1'b1;
      dn_q    <= 1'b1;
      lap_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      ce_q    <= ce_d;
      clr_q   <= clr_d;
      frz_q   <= frz_d;
      mode_q  <= mode_d;
      ss_q    <= StartStop;
      up_q    <= Up;
      dn_q    <= Down;
      lap_q   <= Lap;
    end
  end

  assign CountEnable   = ce_q;
  assign CountDir      = dir_q;
  assign CounterClear  = clr_q;
  assign DisplayFreeze = frz_q;
  assign ModeOutput    = mode_q;
  assign State         = state_q;

endmodule

// File: tb/tb_stopwatch_controller.sv
// Bench for stopwatch_controller: directed scenarios with literal expectations,
// then randomized stimulus, all cross-checked every cycle against a behavioural model.
module tb_stopwatch_controller;

  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_LIM = 3;

  logic       clk = 1'b0;
  logic       Reset = 1'b1;
  logic       StartStop = 1'b0, Up = 1'b0, Down = 1'b0, Lap = 1'b0;
  logic [4:0] Speed = 5'd0;
  logic       AtMax = 1'b0, AtZero = 1'b0;
  logic       CountEnable, CountDir, CounterClear, DisplayFreeze;
  logic [2:0] ModeOutput;
  logic [1:0] State;

  int checks = 0;
  int failures = 0;

  stopwatch_controller #(.DIV_WIDTH(32), .AUTO_STOP(1'b1)) dut (
    .Clk(clk), .Reset(Reset), .StartStop(StartStop), .Up(Up), .Down(Down),
    .Lap(Lap), .Speed(Speed), .AtMax(AtMax), .AtZero(AtZero),
    .CountEnable(CountEnable), .CountDir(CountDir), .CounterClear(CounterClear),
    .DisplayFreeze(DisplayFreeze), .ModeOutput(ModeOutput), .State(State)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: phase = cycles spent in RUNNING since entry or last tick.
  int     m_state = S_IDLE;
  bit     m_dir = 1'b1, m_ce = 1'b0, m_clr = 1'b0, m_frz = 1'b0;
  longint m_phase = 0;
  bit     h_ss = 1'b1, h_up = 1'b1, h_dn = 1'b1, h_lap = 1'b1;

  task automatic model_step();
    bit es, eu, ed, el, bound, tick;
    int ns;
    if (Reset) begin
      m_state = S_IDLE; m_dir = 1'b1; m_ce = 1'b0; m_clr = 1'b0; m_frz = 1'b0;
      m_phase = 0; h_ss = 1'b1; h_up = 1'b1; h_dn = 1'b1; h_lap = 1'b1;
    end else begin
      es = StartStop && !h_ss;
      eu = Up && !h_up;
      ed = Down && !h_dn;
      el = Lap && !h_lap;
      h_ss = StartStop; h_up = Up; h_dn = Down; h_lap = Lap;
      bound = m_dir ? AtMax : AtZero;
      tick = 1'b0;
      if (m_state == S_RUN) begin
        if (m_phase + 1 >= (longint'(1) << Speed)) begin
          tick = 1'b1;
          m_phase = 0;
        end else begin
          m_phase++;
        end
      end
      ns = m_state;
      m_ce = 1'b0;
      m_clr = 1'b0;
      if (m_state == S_IDLE) begin
        if (es) ns = S_RUN;
        else if (el) m_clr = 1'b1;
      end else if (m_state == S_RUN) begin
        m_ce = tick && !bound;
        if (es) ns = S_PAUSE;
        else begin
          if (tick && bound) ns = S_LIM;
          if (el) m_frz = !m_frz;
        end
      end else begin
        if (es) begin
          if (m_state == S_PAUSE || !bound) ns = S_RUN;
        end else if (el) begin
          m_clr = 1'b1;
          ns = S_IDLE;
        end
      end
      if (ns == S_IDLE) m_frz = 1'b0;
      if (ns != S_RUN || m_state != S_RUN) m_phase = 0;
      if (eu && !ed) m_dir = 1'b1;
      else if (ed && !eu) m_dir = 1'b0;
      m_state = ns;
    end
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    chk("model_state", 32'(State), 32'(m_state));
    chk("model_dir", 32'(CountDir), 32'(m_dir));
    chk("model_ce", 32'(CountEnable), 32'(m_ce));
    chk("model_clr", 32'(CounterClear), 32'(m_clr));
    chk("model_frz", 32'(DisplayFreeze), 32'(m_frz));
    chk("model_mode", 32'(ModeOutput), 32'({m_state == S_LIM, m_dir, !m_dir}));
    chk("ce_clr_excl", 32'(CountEnable & CounterClear), 32'd0);
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(State), 32'd0);
    chk({tag, "_dir"}, 32'(CountDir), 32'd1);
    chk({tag, "_mode"}, 32'(ModeOutput), 32'b010);
    chk({tag, "_ce"}, 32'(CountEnable), 32'd0);
    chk({tag, "_clr"}, 32'(CounterClear), 32'd0);
    chk({tag, "_frz"}, 32'(DisplayFreeze), 32'd0);
  endtask

  initial begin
    // Reset and Speed=2 tick cadence
    step(); step();
    chk_reset_vals("reset");
    Reset = 1'b0; Speed = 5'd2; step();
    StartStop = 1'b1; step();
    chk("run_entry_state", 32'(State), S_RUN);
    StartStop = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk($sformatf("spd2_ce_c%0d", k), 32'(CountEnable), 32'((k % 4) == 0));
    end

    // Up held through reset release, then a fresh Down
    Reset = 1'b1; Up = 1'b1; step();
    Reset = 1'b0; step(); step();
    chk("up_held_mode", 32'(ModeOutput), 32'b010);
    chk("up_held_dir", 32'(CountDir), 32'd1);
    Up = 1'b0; Down = 1'b1; step();
    chk("down_dir", 32'(CountDir), 32'd0);
    chk("down_mode", 32'(ModeOutput), 32'b001);
    Down = 1'b0; step();

    // Limit at AtMax, StartStop ignored, recover after Down
    Up = 1'b1; step(); Up = 1'b0; step();
    chk("up_dir", 32'(CountDir), 32'd1);
    Speed = 5'd0; StartStop = 1'b1; step();
    StartStop = 1'b0; step();
    chk("spd0_ce", 32'(CountEnable), 32'd1);
    AtMax = 1'b1; step();
    chk("limit_ce", 32'(CountEnable), 32'd0);
    chk("limit_state", 32'(State), S_LIM);
    chk("limit_mode", 32'(ModeOutput), 32'b110);
    StartStop = 1'b1; step();
    chk("limit_ss_ignored", 32'(State), S_LIM);
    StartStop = 1'b0; Down = 1'b1; step();
    chk("limit_down_mode", 32'(ModeOutput), 32'b101);
    Down = 1'b0; StartStop = 1'b1; step();
    chk("limit_resume_state", 32'(State), S_RUN);
    chk("limit_resume_mode", 32'(ModeOutput), 32'b001);
    StartStop = 1'b0; step();
    chk("limit_resume_ce", 32'(CountEnable), 32'd1);
    AtMax = 1'b0;

    // Lap freeze toggling, pause, clear
    Lap = 1'b1; step(); chk("lap1_frz", 32'(DisplayFreeze), 32'd1);
    Lap = 1'b0; step();
    Lap = 1'b1; step(); chk("lap2_frz", 32'(DisplayFreeze), 32'd0);
    Lap = 1'b0; step();
    Lap = 1'b1; step(); chk("lap3_frz", 32'(DisplayFreeze), 32'd1);
    Lap = 1'b0; StartStop = 1'b1; step();
    chk("pause_state", 32'(State), S_PAUSE);
    StartStop = 1'b0; step();
    Lap = 1'b1; step();
    chk("pclr_clr", 32'(CounterClear), 32'd1);
    chk("pclr_state", 32'(State), S_IDLE);
    chk("pclr_frz", 32'(DisplayFreeze), 32'd0);
    Lap = 1'b0; step();
    chk("pclr_clr_drop", 32'(CounterClear), 32'd0);

    // Simultaneous StartStop+Lap, simultaneous Up+Down
    StartStop = 1'b1; Lap = 1'b1; step();
    chk("sslap_state", 32'(State), S_RUN);
    chk("sslap_clr", 32'(CounterClear), 32'd0);
    StartStop = 1'b0; Lap = 1'b0; step();
    Up = 1'b1; Down = 1'b1; step();
    chk("updown_dir", 32'(CountDir), 32'd0);
    Up = 1'b0; Down = 1'b0; step();

    // Speed drop below running count, then reset mid-run
    Reset = 1'b1; step();
    Reset = 1'b0; Speed = 5'd10; step();
    StartStop = 1'b1; step();
    StartStop = 1'b0;
    repeat (500) step();
    chk("spd10_no_ce", 32'(CountEnable), 32'd0);
    Speed = 5'd3; step();
    chk("spd3_immediate_ce", 32'(CountEnable), 32'd1);
    for (int k = 1; k <= 16; k++) begin
      step();
      chk($sformatf("spd3_ce_c%0d", k), 32'(CountEnable), 32'((k % 8) == 0));
    end
    Reset = 1'b1; step();
    chk_reset_vals("midrun_reset");
    Reset = 1'b0;

    // Randomized stimulus, checked by the model each cycle
    for (int c = 0; c < 4000; c++) begin
      Reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 7) == 0) StartStop = ~StartStop;
      if ($urandom_range(0, 11) == 0) Up = ~Up;
      if ($urandom_range(0, 11) == 0) Down = ~Down;
      if ($urandom_range(0, 9) == 0) Lap = ~Lap;
      if ($urandom_range(0, 49) == 0) Speed = 5'($urandom_range(0, 4));
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 3))
          0: begin AtMax = 1'b1; AtZero = 1'b0; end
          1: begin AtMax = 1'b0; AtZero = 1'b1; end
          default: begin AtMax = 1'b0; AtZero = 1'b0; end
        endcase
      end
      step();
    end

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stopwatch_controller.md
Name: stopwatch_controller

Overview:
Control FSM that sequences the stopwatch up/down counter datapath. It turns raw button levels into run/pause/clear/lap commands and generates the counter's single-cycle count-enable tick from a 2^Speed prescaler. It also drives the direction select and the mode LEDs, and stops counting at the counter limits. It sits between the board buttons and the UpDownCounter / Bin2BCDConverter_4 / SegmentLedHexDecoder chain, and everything runs on the single system clock.

Parameters:
DIV_WIDTH, 32, width of the prescaler counter; must be >= 32 so the full Speed range 0..31 is representable.
AUTO_STOP, 1, 1 = enter LIMIT when the counter is at its bound in the count direction; 0 = suppress ticks at the bound but stay RUNNING.

Ports:
Clk  in  1  system clock; all logic on posedge.
Reset  in  1  synchronous, active-high reset.
StartStop  in  1  debounced button level; rising edge toggles run/pause.
Up  in  1  debounced button level; rising edge selects count up.
Down  in  1  debounced button level; rising edge selects count down.
Lap  in  1  debounced button level; rising edge toggles display freeze, or clears when not running.
Speed  in  5  prescaler exponent; tick period is 2^Speed Clk cycles.
AtMax  in  1  counter value == MAX_VALUE (from the counter's limit flag).
AtZero  in  1  counter value == 0.
CountEnable  out  1  one-cycle tick; counter advances by 1 on it.
CountDir  out  1  1 = up, 0 = down.
CounterClear  out  1  one-cycle synchronous clear pulse to the counter.
DisplayFreeze  out  1  1 = BCD/display latch holds its value (lap).
ModeOutput  out  3  [0] down mode, [1] up mode, [2] limit reached.
State  out  2  current FSM state, for debug and testbench.

Behaviour:
- Reset, sampled on a Clk edge with Reset=1:
  - State=IDLE, CountDir=1, ModeOutput=3'b010, CountEnable=0, CounterClear=0, DisplayFreeze=0, prescaler=0.
  - Button history registers are set to 1, so a button held through reset produces no edge.
  - Reset has priority over every other input.
- Edge detection: ev_X = X & ~X_q, where X_q is the previous-cycle sample of X.
  - Events act in the cycle they are detected; all outputs are registered, so the response is visible one cycle later.
  - Buttons are assumed already debounced and synchronised upstream.
- Event priority within one cycle:
  - StartStop beats Lap; Lap is dropped when both occur.
  - Up and Down are processed independently of StartStop/Lap.
  - Up and Down together: both are ignored.
- Direction:
  - ev_Up sets CountDir=1 and ModeOutput[1:0]=2'b10.
  - ev_Down sets CountDir=0 and ModeOutput[1:0]=2'b01.
  - Allowed in every state; in RUNNING it takes effect from the next tick and the prescaler is not restarted.
- FSM states: IDLE, RUNNING, PAUSED, LIMIT.
  - IDLE: ev_StartStop -> RUNNING; ev_Lap -> pulse CounterClear, stay IDLE.
  - RUNNING: ev_StartStop -> PAUSED; ev_Lap toggles DisplayFreeze.
  - PAUSED: ev_StartStop -> RUNNING; ev_Lap -> pulse CounterClear, DisplayFreeze=0, go to IDLE.
  - LIMIT: ModeOutput[2]=1.
    - ev_StartStop -> RUNNING only if the counter is not at the bound in the current direction (up & AtMax, or down & AtZero); otherwise it is ignored.
    - ev_Lap -> clear, go to IDLE.
    - ModeOutput[2] clears on leaving LIMIT.
- Prescaler:
  - Counts only in RUNNING; it is held at 0 in all other states and cleared on every entry to RUNNING.
  - Terminal value T = (1<<Speed) - 1. When cnt >= T: cnt <= 0 and a tick is generated; otherwise cnt increments.
  - Speed=0 gives a tick every cycle.
  - A Speed decrease below the current cnt produces an immediate tick, with no wrap-around past T.
- Tick and limit handling:
  - On a tick, if (CountDir & AtMax) | (~CountDir & AtZero), then CountEnable stays 0 and, with AUTO_STOP=1, State -> LIMIT.
  - Otherwise CountEnable=1 for exactly one cycle.
  - First CountEnable occurs 2^Speed cycles after the RUNNING entry cycle.
- CounterClear and CountEnable are never high in the same cycle.
- DisplayFreeze is forced to 0 on any transition to IDLE.

Decomposition:
- Package stopwatch_pkg holds:
  - the State encoding: IDLE=2'd0, RUNNING=2'd1, PAUSED=2'd2, LIMIT=2'd3;
  - ModeOutput bit-index constants;
  - the reset constant MODE_RESET=3'b010.
- One sub-module, stopwatch_tick_prescaler: inputs Clk, Reset, Enable, Restart, Speed; output Tick. It implements the prescaler rules above.
- Edge detectors and the FSM stay inline.

Test Plan:
- Reset, Speed=2, StartStop pulse -> State=RUNNING the next cycle; CountEnable high on cycles 4, 8, 12 after entry, each for 1 cycle.
- Up held through a Reset release -> no direction event; ModeOutput=3'b010. A fresh Down press -> CountDir=0, ModeOutput=3'b001 one cycle later.
- RUNNING, Speed=0, count up, AtMax driven to 1 -> no CountEnable, State=LIMIT, ModeOutput[2]=1. StartStop is ignored. After Down, StartStop -> RUNNING and ticks resume.
- RUNNING: Lap -> DisplayFreeze=1; Lap again -> 0. StartStop -> PAUSED; Lap -> CounterClear for 1 cycle, State=IDLE, DisplayFreeze=0.
- StartStop and Lap rising in the same cycle in IDLE -> RUNNING with no CounterClear. Up and Down in the same cycle -> CountDir unchanged.
- RUNNING, Speed=10 with cnt at 500, Speed changed to 3 -> CountEnable next cycle, then every 8 cycles. Reset asserted mid-run -> all outputs at reset values on the next edge.
